btn_event_arbiter: RTL
======================

# btn_event_arbiter

Collects single-cycle press pulses from up to N debounced buttons and serialises them into one in-order event stream for the control logic downstream. Each button has a pending latch. A round-robin arbiter moves pending presses into a small event FIFO. The consumer drains the FIFO through a valid/ready handshake. Presses that cannot be held are coalesced and counted.

## Interface
Parameters:
- N_BTN, 4: number of button inputs; range 2..16.
- DEPTH, 4: event FIFO depth; power of two, range 2..16.
- IDW, $clog2(N_BTN): width of an event id.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- btn_pulse  in  N_BTN  one-cycle press pulses, one bit per button; multiple bits may be high in the same cycle.
- evt_valid  out  1  FIFO head holds an event.
- evt_id  out  IDW  button index of the head event; valid only while evt_valid=1.
- evt_ready  in  1  consumer accepts the head when evt_valid and evt_ready are both 1.
- pending  out  N_BTN  registered pending latches.
- drop_cnt  out  8  saturating count of cycles in which at least one press was coalesced.
- overflow  out  1  sticky; set on any coalesce.
- stat_clr  in  1  synchronous clear of drop_cnt and overflow.

## Operation
Reset values (asynchronous, while reset_n=0):
- pending=0, FIFO empty, evt_valid=0, evt_id=0, drop_cnt=0, overflow=0.
- Round-robin pointer rr=0.

Arbiter (combinational from registered pending and rr):
- Candidates are scanned in order rr, rr+1, …, wrapping modulo N_BTN. The first set bit is the grant g.
- A grant is issued only if pending≠0 and push_ok=1.
- push_ok = (count<DEPTH) or (count==DEPTH and pop this cycle).
- On a grant: g is written into the FIFO tail, and rr becomes (g+1) mod N_BTN, wrapping N_BTN-1 to 0.
- With no grant, rr holds.

Per-button pending update, with grant_i meaning button i is granted this cycle:
- pulse_i=1, pending_i=0: pending_i becomes 1.
- pulse_i=1, pending_i=1, grant_i=1: pending_i stays 1 (the new press is retained), no drop.
- pulse_i=1, pending_i=1, grant_i=0: pending_i stays 1, and a coalesce occurs.
- pulse_i=0, grant_i=1: pending_i becomes 0.

FIFO:
- Circular buffer of DEPTH entries, width IDW, with count 0..DEPTH.
- pop = evt_valid & evt_ready.
- Push and pop in the same cycle leave count unchanged. This is legal both when the FIFO is full and when it holds exactly one entry.
- Popping when empty is impossible by construction; evt_ready is ignored while evt_valid=0.
- evt_valid = (count≠0). evt_id = head entry, driven from registers.

Statistics:
- Any coalesce in a cycle sets overflow=1 and increments drop_cnt by 1, saturating at 255.
- stat_clr=1 has priority over a coalesce in the same cycle: both drop_cnt and overflow become 0.

## Timing
- Press latency: pulse in cycle t, pending set in t+1, grant and push in t+1, evt_valid=1 in t+2 (empty FIFO, no contention).
- Throughput: one event accepted into the FIFO per cycle and one removed per cycle.
- Order: events leave the FIFO in grant order. With K buttons pending and the FIFO not blocked, each is granted within K cycles.
- Full FIFO without pop: no grant, pending is held, rr is held. Grants resume in the cycle a pop occurs.
- Reset asserted mid-operation discards all queued and pending events immediately. The first pulse after reset deasserts follows the press-latency timing above.

## Test plan
- Single press: btn_pulse=4'b0100 in cycle 0, evt_ready=1. Required: pending=4'b0100 in cycle 1; evt_valid=1 with evt_id=2 in cycle 2; evt_valid=0 in cycle 3; drop_cnt=0.
- Simultaneous presses: btn_pulse=4'b1011 in cycle 0 right after reset, evt_ready=1. Required: events 0, 1, 3 on evt_id in cycles 2, 3, 4; rr=0 after the grant of 3.
- Full FIFO and coalesce (DEPTH=4, evt_ready=0):
  - Pulse button 1 in cycles 0, 2, 4, 6, 8, 10. The first four are queued and the fifth sets pending_1.
  - The sixth (cycle 10) coalesces, giving overflow=1 and drop_cnt=1.
  - Then raise evt_ready: five events with id 1 drain on consecutive cycles.
- Push with pop when full: FIFO holds {0,1,2,3}, pending_3=1, evt_ready=1. Required: in the same cycle the FIFO pops 0 and pushes 3, count stays 4, and the next head is 1.
- Statistics: force 300 coalesce cycles, giving drop_cnt=255. Then assert stat_clr in the same cycle as a coalesce: drop_cnt=0 and overflow=0 on the next cycle.
- Reset mid-stream: assert reset_n=0 while count=3 and pending=4'b0110. Required: evt_valid=0, pending=0 and drop_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: latches single-cycle button presses, picks pending
// buttons round-robin into a small event FIFO, and drains that FIFO to the
// consumer through a valid/ready handshake. Presses arriving while their
// button is already pending and not being granted are coalesced and counted.
module btn_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_pulse,
  output logic             evt_valid,
  output logic [IDW-1:0]   evt_id,
  input  logic             evt_ready,
  output logic [N_BTN-1:0] pending,
  output logic [7:0]       drop_cnt,
  output logic             overflow,
  input  logic             stat_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] grant_vec;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   grant_id;
  logic             grant_vld;
  logic             push_ok;
  logic             pop;
  logic             coalesce;

  logic [IDW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic [7:0]       drop_q;
  logic             ovf_q;

  // Round-robin scan of pending buttons starting at rr_q; first hit wins.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pending_q[idx]) begin
        found    = 1'b1;
        grant_id = IDW'(idx);
      end
    end
  end

  assign pop       = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok   = (count_q < CW'(DEPTH)) | pop;
  assign grant_vld = (|pending_q) & push_ok;
  assign grant_vec = grant_vld ? (N_BTN'(1) << grant_id) : '0;

  // A new press on the granted button re-arms its latch; on any other
  // already-pending button it is folded into the existing latch.
  assign pending_d = (pending_q & ~grant_vec) | btn_pulse;
  assign coalesce  = |(btn_pulse & pending_q & ~grant_vec);

  // Pointer advances past the granted button so it goes to the back of the line.
  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      if (grant_id == IDW'(N_BTN - 1)) rr_d = '0;
      else                             rr_d = grant_id + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({grant_vld, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending latches and arbitration pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      rr_q      <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
    end
  end

  // Event FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (grant_vld) begin
        mem_q[wr_ptr_q] <= grant_id;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Drop statistics; clear wins over a coalesce in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (stat_clr) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (coalesce) begin
      ovf_q <= 1'b1;
      if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_id    = mem_q[rd_ptr_q];
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

endmodule
